mic_sample_capture: RTL

//  Producer end of the wave_sample interface: SPI master for the Pmod MIC3 ADC (ADCS7476).
//  - Converts once per sample period and presents the result as a 12-bit sample plus a 10-bit wave_sample.
//  - Generates the clk_sample strobe/clock that the waveform drawer stores samples on.
//  - Sits between the MIC3 pins and the waveform/VGA path, on the 100 MHz board clock.

---
 rtl/mic_pkg.sv | 8 +
 rtl/mic_sample_capture_if.sv | 12 +
 rtl/sample_tick_gen.sv | 27 ++
 rtl/mic_sample_capture.sv | 101 ++++++++++
 4 files changed

// File: rtl/mic_pkg.sv
// Shared definitions for the MIC3 capture path: frame widths and SPI FSM states.
package mic_pkg;
  localparam int unsigned ADC_BITS   = 12;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned WAVE_BITS  = 10;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
endpackage

// File: rtl/mic_sample_capture_if.sv
// wave_sample interface: conversion results and the sample strobe toward the waveform drawer.
interface mic_sample_capture_if;
  import mic_pkg::*;

  logic [ADC_BITS-1:0]  sample_out;
  logic [WAVE_BITS-1:0] wave_sample;
  logic                 sample_valid;
  logic                 clk_sample;

  modport master (output sample_out, wave_sample, sample_valid, clk_sample);
  modport slave  (input  sample_out, wave_sample, sample_valid, clk_sample);
endinterface

// File: rtl/sample_tick_gen.sv
// Sample-period counter: registered end-of-period tick and SAMPLE_HZ square wave.
module sample_tick_gen #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned SAMPLE_HZ = 20_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick,
  output logic clk_sample
);
  localparam int unsigned P  = CLK_HZ / SAMPLE_HZ;
  localparam int unsigned CW = $clog2(P);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      tick       <= 1'b0;
      clk_sample <= 1'b0;
    end else begin
      count      <= (count == CW'(P - 1)) ? '0 : count + 1'b1;
      tick       <= (count == CW'(P - 1));
      clk_sample <= (count < CW'(P / 2));
    end
  end
endmodule

// File: rtl/mic_sample_capture.sv
// SPI master for the Pmod MIC3 (ADCS7476): one 16-bit frame per sample period,
// published as a 12-bit sample and a 10-bit wave_sample with a one-cycle valid pulse.
module mic_sample_capture
  import mic_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned SAMPLE_HZ = 20_000,
  parameter int unsigned SCLK_HALF = 50
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mic_miso,
  output logic                  mic_cs_n,
  output logic                  mic_sclk,
  mic_sample_capture_if.master  wave
);
  localparam int unsigned P  = CLK_HZ / SAMPLE_HZ;
  localparam int unsigned HW = $clog2(SCLK_HALF);
  localparam int unsigned BW = $clog2(FRAME_BITS + 1);

  if (33 * SCLK_HALF + 2 > P) begin : g_bad_period
    $error("mic_sample_capture: conversion does not fit in one sample period");
  end
  if (SCLK_HALF < 2) begin : g_bad_half
    $error("mic_sample_capture: SCLK_HALF must be at least 2");
  end

  logic                  tick;
  logic                  clk_sample_int;
  state_t                state;
  logic [HW-1:0]         half_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [FRAME_BITS-1:0] shift;

  sample_tick_gen #(
    .CLK_HZ    (CLK_HZ),
    .SAMPLE_HZ (SAMPLE_HZ)
  ) u_tick (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .clk_sample (clk_sample_int)
  );

  assign wave.clk_sample = clk_sample_int;

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      mic_cs_n          <= 1'b1;
      mic_sclk          <= 1'b1;
      half_cnt          <= '0;
      bit_cnt           <= '0;
      shift             <= '0;
      wave.sample_out   <= '0;
      wave.wave_sample  <= '0;
      wave.sample_valid <= 1'b0;
    end else begin
      wave.sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          mic_cs_n <= 1'b1;
          mic_sclk <= 1'b1;
          half_cnt <= '0;
          bit_cnt  <= '0;
          if (tick) begin
            state    <= CONV;
            mic_cs_n <= 1'b0;
          end
        end
        CONV: begin
          if (half_cnt == HW'(SCLK_HALF - 1)) begin
            half_cnt <= '0;
            mic_sclk <= ~mic_sclk;
            // The cycle that drives SCLK high is the data sampling point.
            if (!mic_sclk) begin
              shift   <= (shift << 1) | FRAME_BITS'(mic_miso);
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BW'(FRAME_BITS - 1)) state <= DONE;
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        DONE: begin
          if (half_cnt == HW'(SCLK_HALF - 1)) begin
            half_cnt          <= '0;
            mic_cs_n          <= 1'b1;
            wave.sample_out   <= shift[ADC_BITS-1:0];
            wave.wave_sample  <= shift[ADC_BITS-1:ADC_BITS-WAVE_BITS];
            wave.sample_valid <= 1'b1;
            state             <= IDLE;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
